pcin_cascade_rx: RTL and testbench
==================================

PCIN_CASCADE_RX -- requirements
Module: pcin_cascade_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 48: cascade word width.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of 2, at least 2.
REQ-003 SHALL have parameter INREG, default 1: 1 = input capture register before the FIFO; 0 = FIFO written directly from the pins.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port ce, input, 1: clock enable for all state.
REQ-007 SHALL have port pcin, input, WIDTH: cascade data from the upstream slice.
REQ-008 SHALL have port pcin_vld, input, 1: pcin is valid.
REQ-009 SHALL have port pcin_rdy, output, 1: receiver can accept a word.
REQ-010 SHALL have port dout, output, WIDTH: head-of-FIFO word.
REQ-011 SHALL have port dout_vld, output, 1: dout is valid.
REQ-012 SHALL have port dout_rdy, input, 1: consumer takes the word.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1: FIFO occupancy.
REQ-014 SHALL have port ovf, output, 1: sticky overflow flag.

Function
REQ-015 SHALL define accept as pcin_vld && pcin_rdy && ce, and pop as dout_vld && dout_rdy && ce.
REQ-016 SHALL implement a show-ahead FIFO: dout = oldest entry whenever dout_vld=1; dout_vld = (count != 0).
REQ-017 SHALL set pcin_rdy as follows: INREG=0 -> count < DEPTH; INREG=1 -> count + stage_vld < DEPTH, where stage_vld is the input-register occupancy.
REQ-018 SHALL derive pcin_rdy from registered state only, with no combinational path from dout_rdy.
REQ-019 SHALL make an accepted word first visible on dout after 1 edge when INREG=0, and after 2 edges when INREG=1.
REQ-020 SHALL not bypass an empty FIFO: a word accepted while empty appears on dout only after the REQ-019 latency.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and preserve order.
REQ-022 SHALL, when full, hold pcin_rdy=0, so a pop in the same cycle frees space only from the next cycle.
REQ-023 SHALL wrap read and write pointers modulo DEPTH, with no loss or duplication across the wrap.
REQ-024 SHALL, with INREG=1, move the captured word into the FIFO on the next ce edge and clear stage_vld, unless a new word is accepted in that same edge.
REQ-025 SHALL, when ce=0, freeze all state: no accept, no pop, outputs held.
REQ-026 SHALL set ovf when pcin_vld=1, pcin_rdy=0 and ce=1, and SHALL drop that word.
REQ-027 SHALL clear ovf only by reset.

Reset
REQ-028 SHALL, on rst_n=0 at a clk edge, force count=0, pointers=0, stage_vld=0, ovf=0, dout_vld=0, dout=0 and pcin_rdy=1 on the following cycle, regardless of ce.
REQ-029 SHALL discard all stored words when reset is asserted mid-transfer; no word accepted before reset appears afterward.

Configuration
REQ-030 SHALL, when macro PCIN_CASC_RX_PARITY_EN is defined, add input pcin_par (1 bit, even parity over pcin) and output par_err (1 bit, sticky, reset 0).
REQ-031 SHALL, with PCIN_CASC_RX_PARITY_EN defined, check parity on every accept; on a mismatch the word is still stored and par_err is set on that edge.
REQ-032 SHALL, without PCIN_CASC_RX_PARITY_EN, omit the pcin_par and par_err ports and all parity logic.

Verification
REQ-033 SHALL cover latency: INREG=0, push 48'h1 at cycle 0 -> dout_vld=1 and dout=48'h1 at cycle 1; with INREG=1 -> same response at cycle 2.
REQ-034 SHALL cover fill/drain: DEPTH=4, dout_rdy=0, push 5 words with pcin_vld held -> pcin_rdy=0 after 4 (INREG=0), ovf=1, 5th word dropped; then dout_rdy=1 -> words 1..4 in order, dout_vld=0 after.
REQ-035 SHALL cover wrap: 10 words streamed with pcin_vld=1 and dout_rdy=1 continuously -> output order 1..10 with no gaps after fill, count constant at 1.
REQ-036 SHALL cover ce freeze: 2 words stored, ce=0 for 3 cycles with pcin_vld=1 and dout_rdy=1 -> count stays 2, dout unchanged, ovf stays 0.
REQ-037 SHALL cover mid-operation reset: 3 words stored, rst_n=0 for one edge -> count=0, dout_vld=0 and ovf=0 next cycle; old data never appears on dout.
REQ-038 SHALL cover parity (macro defined): push pcin=48'h3 with pcin_par=1 -> par_err=1, word still delivered; pcin_par=0 -> par_err stays 0.

Source files
------------

// File: rtl/pcin_cascade_rx.sv
// pcin_cascade_rx
//   Receiver for a cascade word stream from an upstream slice. An optional
//   input capture register feeds a show-ahead FIFO. Back-pressure is computed
//   from registered occupancy only. A word offered while the receiver is not
//   ready is dropped and sets a sticky overflow flag.
//
// Parameters
//   WIDTH  cascade word width
//   DEPTH  FIFO entries (power of 2, >= 2)
//   INREG  1: capture register in front of the FIFO, 0: FIFO written from pins
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   ce              clock enable for all state
//   pcin, pcin_vld  incoming word and its valid
//   pcin_rdy        receiver can accept a word
//   dout, dout_vld  oldest stored word and its valid
//   dout_rdy        consumer takes the word
//   count           FIFO occupancy
//   ovf             sticky overflow (cleared only by reset)
//   pcin_par        even parity of pcin        (PCIN_CASC_RX_PARITY_EN only)
//   par_err         sticky parity error flag   (PCIN_CASC_RX_PARITY_EN only)
//
// Optional feature macro: PCIN_CASC_RX_PARITY_EN

module pcin_cascade_rx #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    parameter int INREG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic [WIDTH-1:0]           pcin,
    input  logic                       pcin_vld,
`ifdef PCIN_CASC_RX_PARITY_EN
    input  logic                       pcin_par,
    output logic                       par_err,
`endif
    output logic                       pcin_rdy,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             stage_vld;
    logic             fifo_push;
    logic [WIDTH-1:0] fifo_din;
    logic             accept;
    logic             pop;

    assign accept   = pcin_vld && pcin_rdy && ce;
    assign dout_vld = (count != '0);
    assign pop      = dout_vld && dout_rdy && ce;
    // Gated so dout reads as zero whenever nothing is stored.
    assign dout     = dout_vld ? mem[rd_ptr] : '0;

    generate
        if (INREG != 0) begin : g_inreg
            logic [WIDTH-1:0] stage_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_vld  <= 1'b0;
                    stage_data <= '0;
                end else if (ce) begin
                    stage_vld <= accept;
                    if (accept) begin
                        stage_data <= pcin;
                    end
                end
            end

            // Ready counts the staged word, so the FIFO always has room for
            // it on the next enabled edge; the transfer is unconditional.
            assign pcin_rdy  = (count + CW'(stage_vld)) < DEPTH_C;
            assign fifo_push = stage_vld && ce;
            assign fifo_din  = stage_data;
        end else begin : g_direct
            assign stage_vld = 1'b0;
            assign pcin_rdy  = count < DEPTH_C;
            assign fifo_push = accept;
            assign fifo_din  = pcin;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= fifo_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (ce) begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (fifo_push && !pop) begin
                count <= count + CW'(1);
            end else if (!fifo_push && pop) begin
                count <= count - CW'(1);
            end
            if (pcin_vld && !pcin_rdy) begin
                ovf <= 1'b1;
            end
        end
    end

`ifdef PCIN_CASC_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (accept && ((^pcin) != pcin_par)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pcin_cascade_rx.sv
// Directed bench for pcin_cascade_rx. Two instances share all inputs:
// u_d0 with INREG=0 and u_d1 with INREG=1, both WIDTH=48, DEPTH=4.

module tb_pcin_cascade_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [47:0] pcin;
    logic        pcin_vld;
    logic        dout_rdy;
    logic        par;

    logic        rdy0, vld0, ovf0, perr0;
    logic        rdy1, vld1, ovf1, perr1;
    logic [47:0] dout0, dout1;
    logic [2:0]  cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcin_cascade_rx #(.WIDTH(48), .DEPTH(4), .INREG(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pcin(pcin), .pcin_vld(pcin_vld),
`ifdef PCIN_CASC_RX_PARITY_EN
        .pcin_par(par), .par_err(perr0),
`endif
        .pcin_rdy(rdy0), .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy),
        .count(cnt0), .ovf(ovf0)
    );

    pcin_cascade_rx #(.WIDTH(48), .DEPTH(4), .INREG(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pcin(pcin), .pcin_vld(pcin_vld),
`ifdef PCIN_CASC_RX_PARITY_EN
        .pcin_par(par), .par_err(perr1),
`endif
        .pcin_rdy(rdy1), .dout(dout1), .dout_vld(vld1), .dout_rdy(dout_rdy),
        .count(cnt1), .ovf(ovf1)
    );

`ifndef PCIN_CASC_RX_PARITY_EN
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pcin_vld = 1'b0; dout_rdy = 1'b0; ce = 1'b1;
        pcin = '0; par = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; pcin_vld = 1'b0; dout_rdy = 1'b0;
        step();
        rst_n = 1'b1; ce = 1'b1;
        n_checks++; if (cnt0 !== 3'd0)  begin n_fail++; $display("FAIL reset_count0 got %0d exp 0", cnt0); end
        n_checks++; if (vld0 !== 1'b0)  begin n_fail++; $display("FAIL reset_dout_vld0 got %b exp 0", vld0); end
        n_checks++; if (dout0 !== 48'h0) begin n_fail++; $display("FAIL reset_dout0 got %h exp 0", dout0); end
        n_checks++; if (rdy0 !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy0 got %b exp 1", rdy0); end
        n_checks++; if (ovf0 !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf0 got %b exp 0", ovf0); end
        n_checks++; if (cnt1 !== 3'd0)  begin n_fail++; $display("FAIL reset_count1 got %0d exp 0", cnt1); end
        n_checks++; if (rdy1 !== 1'b1)  begin n_fail++; $display("FAIL reset_rdy1 got %b exp 1", rdy1); end
        n_checks++; if (vld1 !== 1'b0)  begin n_fail++; $display("FAIL reset_dout_vld1 got %b exp 0", vld1); end
    endtask

    task automatic test_latency();
        do_reset();
        pcin = 48'h1; pcin_vld = 1'b1;
        step();
        pcin_vld = 1'b0;
        n_checks++; if (vld0 !== 1'b1)  begin n_fail++; $display("FAIL lat0_vld got %b exp 1", vld0); end
        n_checks++; if (dout0 !== 48'h1) begin n_fail++; $display("FAIL lat0_dout got %h exp 1", dout0); end
        n_checks++; if (vld1 !== 1'b0)  begin n_fail++; $display("FAIL lat1_early_vld got %b exp 0", vld1); end
        step();
        n_checks++; if (vld1 !== 1'b1)  begin n_fail++; $display("FAIL lat1_vld got %b exp 1", vld1); end
        n_checks++; if (dout1 !== 48'h1) begin n_fail++; $display("FAIL lat1_dout got %h exp 1", dout1); end
        dout_rdy = 1'b1;
        step();
        dout_rdy = 1'b0;
        n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL lat_drain0 got %0d exp 0", cnt0); end
        n_checks++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL lat_drain1 got %0d exp 0", cnt1); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        pcin_vld = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pcin = 48'(i);
            step();
            n_checks++;
            if (rdy0 !== (i < 4)) begin n_fail++; $display("FAIL fill_rdy0 word %0d got %b exp %b", i, rdy0, (i < 4)); end
        end
        pcin_vld = 1'b0;
        n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL fill_ovf0 got %b exp 1", ovf0); end
        n_checks++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL fill_ovf1 got %b exp 1", ovf1); end
        n_checks++; if (cnt0 !== 3'd4) begin n_fail++; $display("FAIL fill_count0 got %0d exp 4", cnt0); end
        n_checks++; if (cnt1 !== 3'd4) begin n_fail++; $display("FAIL fill_count1 got %0d exp 4", cnt1); end
        dout_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (dout0 !== 48'(k)) begin n_fail++; $display("FAIL drain0 word %0d got %h exp %h", k, dout0, 48'(k)); end
            n_checks++; if (dout1 !== 48'(k)) begin n_fail++; $display("FAIL drain1 word %0d got %h exp %h", k, dout1, 48'(k)); end
            step();
        end
        dout_rdy = 1'b0;
        n_checks++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL drain_empty0 got %b exp 0", vld0); end
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL drain_empty1 got %b exp 0", vld1); end
        n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky0 got %b exp 1", ovf0); end
    endtask

    task automatic test_wrap();
        do_reset();
        pcin_vld = 1'b1; dout_rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            pcin = 48'(i);
            step();
            n_checks++; if (dout0 !== 48'(i) || vld0 !== 1'b1) begin n_fail++; $display("FAIL wrap0 step %0d got %h/%b exp %h/1", i, dout0, vld0, 48'(i)); end
            n_checks++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL wrap_count0 step %0d got %0d exp 1", i, cnt0); end
            if (i >= 2) begin
                n_checks++; if (dout1 !== 48'(i - 1) || cnt1 !== 3'd1) begin n_fail++; $display("FAIL wrap1 step %0d got %h/%0d exp %h/1", i, dout1, cnt1, 48'(i - 1)); end
            end
        end
        pcin_vld = 1'b0;
        step();
        n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL wrap_end0 got %0d exp 0", cnt0); end
        n_checks++; if (dout1 !== 48'd10) begin n_fail++; $display("FAIL wrap_end1 got %h exp a", dout1); end
        n_checks++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf got %b%b exp 00", ovf0, ovf1); end
        step();
        dout_rdy = 1'b0;
        n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL wrap_empty1 got %b exp 0", vld1); end
    endtask

    task automatic test_ce_freeze();
        do_reset();
        pcin_vld = 1'b1;
        pcin = 48'hA; step();
        pcin = 48'hB; step();
        ce = 1'b0; pcin = 48'hC; dout_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (cnt0 !== 3'd2 || dout0 !== 48'hA) begin n_fail++; $display("FAIL freeze0 cyc %0d got %0d/%h exp 2/a", i, cnt0, dout0); end
            n_checks++; if (cnt1 !== 3'd1 || dout1 !== 48'hA) begin n_fail++; $display("FAIL freeze1 cyc %0d got %0d/%h exp 1/a", i, cnt1, dout1); end
            n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL freeze_ovf0 cyc %0d got %b exp 0", i, ovf0); end
        end
        ce = 1'b1; pcin_vld = 1'b0; dout_rdy = 1'b0;
        step();
        n_checks++; if (cnt1 !== 3'd2) begin n_fail++; $display("FAIL unfreeze1 got %0d exp 2", cnt1); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pcin_vld = 1'b1;
        pcin = 48'h11; step();
        pcin = 48'h22; step();
        pcin = 48'h33; step();
        pcin_vld = 1'b0;
        n_checks++; if (cnt0 !== 3'd3) begin n_fail++; $display("FAIL pre_reset0 got %0d exp 3", cnt0); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_checks++; if (cnt0 !== 3'd0 || vld0 !== 1'b0 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL midrst0 got %0d/%b/%b exp 0/0/0", cnt0, vld0, ovf0); end
        n_checks++; if (cnt1 !== 3'd0 || vld1 !== 1'b0) begin n_fail++; $display("FAIL midrst1 got %0d/%b exp 0/0", cnt1, vld1); end
        dout_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (vld0 !== 1'b0 || vld1 !== 1'b0) begin n_fail++; $display("FAIL stale cyc %0d got %b%b exp 00", i, vld0, vld1); end
        end
        dout_rdy = 1'b0;
        pcin = 48'h44; pcin_vld = 1'b1; step(); pcin_vld = 1'b0;
        n_checks++; if (dout0 !== 48'h44) begin n_fail++; $display("FAIL post_rst_word0 got %h exp 44", dout0); end
        step();
        n_checks++; if (dout1 !== 48'h44 || cnt1 !== 3'd1) begin n_fail++; $display("FAIL post_rst_word1 got %h/%0d exp 44/1", dout1, cnt1); end
    endtask

`ifdef PCIN_CASC_RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        pcin = 48'h3; par = 1'b1; pcin_vld = 1'b1;
        step();
        pcin_vld = 1'b0;
        n_checks++; if (perr0 !== 1'b1 || perr1 !== 1'b1) begin n_fail++; $display("FAIL par_err_set got %b%b exp 11", perr0, perr1); end
        n_checks++; if (dout0 !== 48'h3) begin n_fail++; $display("FAIL par_word0 got %h exp 3", dout0); end
        step();
        n_checks++; if (dout1 !== 48'h3) begin n_fail++; $display("FAIL par_word1 got %h exp 3", dout1); end
        do_reset();
        pcin = 48'h3; par = 1'b0; pcin_vld = 1'b1;
        step();
        pcin_vld = 1'b0;
        n_checks++; if (perr0 !== 1'b0 || perr1 !== 1'b0) begin n_fail++; $display("FAIL par_err_clean got %b%b exp 00", perr0, perr1); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; ce = 1'b1; pcin = '0; pcin_vld = 1'b0;
        dout_rdy = 1'b0; par = 1'b0;
        step();
        test_reset();
        test_latency();
        test_fill_drain();
        test_wrap();
        test_ce_freeze();
        test_mid_reset();
`ifdef PCIN_CASC_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
